// File: rtl/loop_control_if.sv
// Command/status bundle between the loop controller and its host/engines.
// The master modport drives keys, chunk select, requests and engine completions;
// the slave modport (the controller) drives state, start/stop pulses and latched selection.
interface loop_control_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned ADDR_W = 23
);
  logic [3:0]        i_key;
  logic [NUM_CH-1:0] i_sw;
  logic              i_mix_req;
  logic [4:0]        i_pitch_cfg;
  logic              i_rec_done;
  logic              i_play_done;
  logic              i_mix_done;
  logic              i_pitch_done;

  logic [2:0]        o_state;
  logic              o_rec_start;
  logic              o_play_start;
  logic              o_mix_start;
  logic              o_pitch_start;
  logic              o_stop;
  logic [ADDR_W-1:0] o_addr;
  logic [NUM_CH-1:0] o_mix_mask;
  logic [4:0]        o_pitch_cfg;
  logic              o_err;

  modport master (
    output i_key, i_sw, i_mix_req, i_pitch_cfg,
    output i_rec_done, i_play_done, i_mix_done, i_pitch_done,
    input  o_state, o_rec_start, o_play_start, o_mix_start, o_pitch_start,
    input  o_stop, o_addr, o_mix_mask, o_pitch_cfg, o_err
  );

  modport slave (
    input  i_key, i_sw, i_mix_req, i_pitch_cfg,
    input  i_rec_done, i_play_done, i_mix_done, i_pitch_done,
    output o_state, o_rec_start, o_play_start, o_mix_start, o_pitch_start,
    output o_stop, o_addr, o_mix_mask, o_pitch_cfg, o_err
  );
endinterface

// File: rtl/loop_control_core.sv
// Loop-station command controller: turns key edges / mix requests into engine start
// pulses, latches the selected chunk, and supervises stop with a completion timeout.
// Optional pitch engine support is compiled in with macro LOOP_CTRL_PITCH_EN.
module loop_control_core #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned CHUNK_SHIFT = 20,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic         i_clk,
  input logic         i_rst,
  loop_control_if.slave bus
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRec      = 3'd1,
    StPlay     = 3'd2,
    StMix      = 3'd3,
    StPitch    = 3'd4,
    StStopping = 3'd5
  } state_e;

  state_e            state_q, state_d;
  state_e            owner_q, owner_d;   // engine being stopped while in StStopping
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        key_prev_q;
  logic              armed_q;            // low for the first cycle after reset
  logic              rec_start_q, rec_start_d;
  logic              play_start_q, play_start_d;
  logic              mix_start_q, mix_start_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              err_q, err_d;

  logic [3:0]        key_rise;
  logic              rec_ev, play_ev, stop_ev, pitch_ev;
  logic              sw_onehot, sw_nonzero;
  logic [IdxW-1:0]   sel_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic              owner_done;

`ifdef LOOP_CTRL_PITCH_EN
  logic              pitch_start_q, pitch_start_d;
  logic [4:0]        pcfg_q, pcfg_d;
`else
  logic              unused_pitch;
  assign unused_pitch = ^{key_rise[3], bus.i_pitch_cfg, bus.i_pitch_done};
`endif

  // Edge detection; a key already held when reset releases is absorbed by armed_q.
  assign key_rise = armed_q ? (bus.i_key & ~key_prev_q) : 4'b0000;
  assign rec_ev   = key_rise[0];
  assign play_ev  = key_rise[1];
  assign stop_ev  = key_rise[2];
`ifdef LOOP_CTRL_PITCH_EN
  assign pitch_ev = key_rise[3];
`else
  assign pitch_ev = 1'b0;
`endif

  assign sw_nonzero = |bus.i_sw;
  assign sw_onehot  = sw_nonzero && ((bus.i_sw & (bus.i_sw - 1'b1)) == '0);

  // Chunk index of the selected switch; only meaningful when one-hot.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.i_sw[i]) sel_idx = IdxW'(i);
    end
  end

  assign sel_addr = ADDR_W'(sel_idx) << CHUNK_SHIFT;

  // Completion of the engine that was told to stop.
  always_comb begin
    owner_done = 1'b0;
    case (owner_q)
      StRec:   owner_done = bus.i_rec_done;
      StPlay:  owner_done = bus.i_play_done;
      StMix:   owner_done = bus.i_mix_done;
`ifdef LOOP_CTRL_PITCH_EN
      StPitch: owner_done = bus.i_pitch_done;
`endif
      default: owner_done = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    rec_start_d  = 1'b0;
    play_start_d = 1'b0;
    mix_start_d  = 1'b0;
    stop_d       = 1'b0;
    addr_d       = addr_q;
    mask_d       = mask_q;
    err_d        = err_q;
`ifdef LOOP_CTRL_PITCH_EN
    pitch_start_d = 1'b0;
    pcfg_d        = pcfg_q;
`endif

    case (state_q)
      StIdle: begin
        // Highest-priority pending command wins; rejection does not fall through.
        if (rec_ev) begin
          if (sw_onehot) begin
            state_d     = StRec;
            rec_start_d = 1'b1;
            addr_d      = sel_addr;
            err_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (play_ev) begin
          if (sw_onehot) begin
            state_d      = StPlay;
            play_start_d = 1'b1;
            addr_d       = sel_addr;
            err_d        = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.i_mix_req) begin
          if (sw_nonzero) begin
            state_d     = StMix;
            mix_start_d = 1'b1;
            mask_d      = bus.i_sw;
            err_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (pitch_ev) begin
`ifdef LOOP_CTRL_PITCH_EN
          if (sw_onehot) begin
            state_d       = StPitch;
            pitch_start_d = 1'b1;
            addr_d        = sel_addr;
            pcfg_d        = bus.i_pitch_cfg;
            err_d         = 1'b0;
          end else begin
            err_d = 1'b1;
          end
`endif
        end
      end

      StRec, StPlay, StMix, StPitch: begin
        // Own done beats a simultaneous STOP; foreign dones are ignored.
        if ((state_q == StRec   && bus.i_rec_done)  ||
            (state_q == StPlay  && bus.i_play_done) ||
            (state_q == StMix   && bus.i_mix_done)
`ifdef LOOP_CTRL_PITCH_EN
            || (state_q == StPitch && bus.i_pitch_done)
`endif
           ) begin
          state_d = StIdle;
        end else if (stop_ev) begin
          state_d = StStopping;
          owner_d = state_q;
          stop_d  = 1'b1;
          cnt_d   = CntW'(TIMEOUT);
        end
      end

      StStopping: begin
        if (owner_done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State, history and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      owner_q      <= StIdle;
      cnt_q        <= '0;
      key_prev_q   <= 4'b0000;
      armed_q      <= 1'b0;
      rec_start_q  <= 1'b0;
      play_start_q <= 1'b0;
      mix_start_q  <= 1'b0;
      stop_q       <= 1'b0;
      addr_q       <= '0;
      mask_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      key_prev_q   <= bus.i_key;
      armed_q      <= 1'b1;
      rec_start_q  <= rec_start_d;
      play_start_q <= play_start_d;
      mix_start_q  <= mix_start_d;
      stop_q       <= stop_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      err_q        <= err_d;
    end
  end

`ifdef LOOP_CTRL_PITCH_EN
  // Pitch engine start pulse and latched configuration.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pitch_start_q <= 1'b0;
      pcfg_q        <= 5'd0;
    end else begin
      pitch_start_q <= pitch_start_d;
      pcfg_q        <= pcfg_d;
    end
  end

  assign bus.o_pitch_start = pitch_start_q;
  assign bus.o_pitch_cfg   = pcfg_q;
`else
  assign bus.o_pitch_start = 1'b0;
  assign bus.o_pitch_cfg   = 5'd0;
`endif

  assign bus.o_state      = state_q;
  assign bus.o_rec_start  = rec_start_q;
  assign bus.o_play_start = play_start_q;
  assign bus.o_mix_start  = mix_start_q;
  assign bus.o_stop       = stop_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_mix_mask   = mask_q;
  assign bus.o_err        = err_q;

endmodule
